// File: rtl/risc_instruction_fetch_if.sv
// Instruction-fetch bus: memory request/response, redirect input and decoder-side queue head.
// master = fetch unit, slave = memory/decoder/branch side.
interface risc_instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr, id_valid, id_instruction, id_pc, misalign_err,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instruction, id_pc, misalign_err,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/risc_instruction_fetch.sv
// Instruction fetch: one-outstanding memory requester feeding a PC-tagged instruction queue.
// Optional macro RISC_IFETCH_MISALIGN_EN halts fetch on a misaligned redirect target.
module risc_instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic                     clk,
    input logic                     reset,
    risc_instruction_fetch_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    // Handshakes: a request transfers when imem_req && imem_gnt; responses return in order,
    // one per granted request, flagged by imem_rvalid; the decoder pops when id_valid && id_ready.
    logic [31:0]   fetch_pc;
    logic [31:0]   out_pc;
    logic          outstanding;
    logic          discard;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic          halted;

    logic          retiring;
    logic          push;
    logic          pop;
    logic          queue_valid;
    logic          req;
    logic          fire;
    logic [OW-1:0] occ;
    logic [31:0]   target_pc;

    assign target_pc = {bus.redirect_pc[31:2], 2'b00};

    // Occupancy projects the queue after this edge plus the request still in flight,
    // so a new grant can never produce a response that finds the queue full.
    always_comb begin
        retiring    = outstanding & bus.imem_rvalid;
        push        = retiring & ~discard & ~bus.redirect;
        queue_valid = (count != '0);
        pop         = queue_valid & bus.id_ready;
        occ         = OW'(count);
        if (push) occ = occ + OW'(1);
        if (pop) occ = occ - OW'(1);
        if (outstanding && !bus.imem_rvalid) occ = occ + OW'(1);
        req  = reset & ~bus.redirect & ~halted
             & (~outstanding | bus.imem_rvalid)
             & (occ < OW'(FIFO_DEPTH));
        fire = req & bus.imem_gnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            out_pc      <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (bus.redirect) begin
            // A response still pending at redirect stays outstanding but is marked for discard.
            fetch_pc    <= target_pc;
            outstanding <= outstanding & ~bus.imem_rvalid;
            discard     <= outstanding & ~bus.imem_rvalid;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + 32'd4;
                out_pc   <= fetch_pc;
            end
            if (fire) outstanding <= 1'b1;
            else if (retiring) outstanding <= 1'b0;
            if (retiring) discard <= 1'b0;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]    <= out_pc;
        end
    end

`ifdef RISC_IFETCH_MISALIGN_EN
    logic misalign_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign_q <= 1'b0;
        else if (bus.redirect) misalign_q <= (bus.redirect_pc[1:0] != 2'b00);
    end
    assign halted = misalign_q;
`else
    logic unused_pc_low;
    assign unused_pc_low = ^bus.redirect_pc[1:0];
    assign halted        = 1'b0;
`endif

    assign bus.imem_req       = req;
    assign bus.imem_addr      = fetch_pc;
    assign bus.id_valid       = queue_valid;
    assign bus.id_instruction = queue_valid ? instr_mem[rd_ptr] : 32'h0;
    assign bus.id_pc          = queue_valid ? pc_mem[rd_ptr] : 32'h0;
    assign bus.misalign_err   = halted;
endmodule

// File: tb/tb_risc_instruction_fetch.sv
// Directed table-driven bench for risc_instruction_fetch (FIFO_DEPTH=2, RESET_PC=0).
module tb_risc_instruction_fetch;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    risc_instruction_fetch_if bus ();

    risc_instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] ins;
        logic [31:0] ipc;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(logic rst_n, logic gnt, logic rv, logic [31:0] rdata,
                                logic redir, logic [31:0] rpc, logic rdy, logic req,
                                logic [31:0] addr, logic idv, logic [31:0] ins,
                                logic [31:0] ipc);
        vec_t v;
        v.rst_n = rst_n; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.req = req;
        v.addr = addr; v.idv = idv; v.ins = ins; v.ipc = ipc;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic redir, input logic [31:0] rpc, input logic rdy);
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rdata;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.id_ready    = rdy;
    endtask

    task automatic check_outputs(input string tag, input int idx, input logic req,
                                 input logic [31:0] addr, input logic idv,
                                 input logic [31:0] ins, input logic [31:0] ipc,
                                 input logic mis);
        check({tag, "_req"},  idx, 32'(bus.imem_req), 32'(req));
        check({tag, "_addr"}, idx, bus.imem_addr, addr);
        check({tag, "_idv"},  idx, 32'(bus.id_valid), 32'(idv));
        check({tag, "_ins"},  idx, bus.id_instruction, ins);
        check({tag, "_ipc"},  idx, bus.id_pc, ipc);
        check({tag, "_mis"},  idx, 32'(bus.misalign_err), 32'(mis));
    endtask

    initial begin
        //            rst g rv rdata          rd rpc          rdy req addr         idv ins            ipc
        vecs[0]  = mk(1, 1, 0, 32'h0,         0, 32'h0,       1,  1, 32'h0,        0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 1, 1, 32'hA000_0000, 0, 32'h0,       1,  1, 32'h4,        0, 32'h0,         32'h0);
        vecs[2]  = mk(1, 1, 1, 32'hA000_0004, 0, 32'h0,       1,  1, 32'h8,        1, 32'hA000_0000, 32'h0);
        vecs[3]  = mk(1, 0, 1, 32'hA000_0008, 0, 32'h0,       1,  1, 32'hC,        1, 32'hA000_0004, 32'h4);
        vecs[4]  = mk(1, 0, 0, 32'h0,         0, 32'h0,       1,  1, 32'hC,        1, 32'hA000_0008, 32'h8);
        vecs[5]  = mk(1, 0, 0, 32'h0,         0, 32'h0,       1,  1, 32'hC,        0, 32'h0,         32'h0);
        vecs[6]  = mk(1, 1, 0, 32'h0,         0, 32'h0,       0,  1, 32'hC,        0, 32'h0,         32'h0);
        vecs[7]  = mk(1, 1, 1, 32'hA000_000C, 0, 32'h0,       0,  1, 32'h10,       0, 32'h0,         32'h0);
        vecs[8]  = mk(1, 1, 1, 32'hA000_0010, 0, 32'h0,       0,  0, 32'h14,       1, 32'hA000_000C, 32'hC);
        vecs[9]  = mk(1, 1, 0, 32'h0,         0, 32'h0,       0,  0, 32'h14,       1, 32'hA000_000C, 32'hC);
        vecs[10] = mk(1, 1, 0, 32'h0,         0, 32'h0,       1,  1, 32'h14,       1, 32'hA000_000C, 32'hC);
        vecs[11] = mk(1, 1, 0, 32'h0,         0, 32'h0,       0,  0, 32'h18,       1, 32'hA000_0010, 32'h10);
        vecs[12] = mk(1, 1, 1, 32'hA000_0014, 1, 32'h100,     0,  0, 32'h18,       1, 32'hA000_0010, 32'h10);
        vecs[13] = mk(1, 1, 0, 32'h0,         0, 32'h0,       1,  1, 32'h100,      0, 32'h0,         32'h0);
        vecs[14] = mk(1, 1, 0, 32'h0,         1, 32'h200,     1,  0, 32'h104,      0, 32'h0,         32'h0);
        vecs[15] = mk(1, 1, 1, 32'hDEAD_BEEF, 0, 32'h0,       1,  1, 32'h200,      0, 32'h0,         32'h0);
        vecs[16] = mk(1, 1, 0, 32'h0,         0, 32'h0,       1,  0, 32'h204,      0, 32'h0,         32'h0);
        vecs[17] = mk(1, 1, 1, 32'hA000_0200, 0, 32'h0,       1,  1, 32'h204,      0, 32'h0,         32'h0);
        vecs[18] = mk(1, 0, 0, 32'h0,         0, 32'h0,       1,  0, 32'h208,      1, 32'hA000_0200, 32'h200);
        vecs[19] = mk(0, 0, 0, 32'h0,         0, 32'h0,       1,  0, 32'h0,        0, 32'h0,         32'h0);
        vecs[20] = mk(1, 1, 1, 32'hBADB_AD00, 0, 32'h0,       1,  1, 32'h0,        0, 32'h0,         32'h0);
        vecs[21] = mk(1, 0, 0, 32'h0,         0, 32'h0,       1,  0, 32'h4,        0, 32'h0,         32'h0);
        vecs[22] = mk(1, 0, 1, 32'hA000_0000, 0, 32'h0,       1,  1, 32'h4,        0, 32'h0,         32'h0);
        vecs[23] = mk(1, 0, 0, 32'h0,         0, 32'h0,       1,  1, 32'h4,        1, 32'hA000_0000, 32'h0);

        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        check_outputs("reset", 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset = vecs[i].rst_n;
            drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].redir, vecs[i].rpc,
                  vecs[i].rdy);
            #2;
            check_outputs("vec", i, vecs[i].req, vecs[i].addr, vecs[i].idv, vecs[i].ins,
                          vecs[i].ipc, 1'b0);
        end

        // Misaligned redirect followed by an aligned one; queue is empty, nothing outstanding.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h102, 1'b1);
        #2;
        check_outputs("mis_redir", 0, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef RISC_IFETCH_MISALIGN_EN
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            #2;
            check("mis_halt_req", k, 32'(bus.imem_req), 32'h0);
            check("mis_halt_err", k, 32'(bus.misalign_err), 32'h1);
        end
`else
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #2;
        check_outputs("mis_off", 0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
`endif
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
        #2;
        check("realign_req", 0, 32'(bus.imem_req), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #2;
        check_outputs("realign", 0, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
